vec_mem_seq: RTL and testbench
==============================

# vec_mem_seq

Vector memory sequencer sitting directly downstream of the DRAM address unit. It latches the 16-bit base address that unit produces, then walks VLEN consecutive DRAM words, either loading them into a vector register (VRF write port) or storing a vector register to DRAM (VRF read port). It owns the DRAM strobes and data bus for the duration of one vector memory instruction and reports completion to the control FSM.

## Interface
- VLEN, 16: elements per vector; power of two, 2..64
- DATA_W, 16: element and DRAM word width
- ADDR_W, 16: DRAM address width
- Clk1  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a vector access; sampled only in IDLE
- isStore  in  1  0 = load (DRAM->VRF), 1 = store (VRF->DRAM); latched with start
- baseAddr  in  ADDR_W  address of element 0; latched with start
- vreg  in  3  target/source vector register; latched with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the access completes
- memAddr  out  ADDR_W  DRAM word address
- memRd / memWr  out  1  DRAM read / write strobes (never both high)
- memReady  in  1  DRAM accepts the current strobe this cycle
- memWdata  out  DATA_W  store data
- memRdata  in  DATA_W  load data, valid exactly one cycle after an accepted read
- vrfSel  out  3  latched vreg
- vrfIdx  out  log2(VLEN)  element index for VRF read (store) or write (load)
- vrfWrEn  out  1  VRF element write strobe
- vrfWrData  out  DATA_W  load data to VRF
- vrfRdData  in  DATA_W  combinational VRF read of (vrfSel, vrfIdx)

## Operation
- States: IDLE, LOAD, STORE, DRAIN, DONE.
- IDLE: start=1 latches baseAddr/isStore/vreg, clears issue index i and write index w; next state LOAD or STORE. start while not IDLE is ignored.
- Element address = baseAddr + i*STRIDE (STRIDE=1 unless configured), computed modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000 silently.
- LOAD: memRd=1, memAddr=element address of i. When memReady=1, i increments. Each accepted read produces, next cycle, vrfWrEn=1, vrfIdx=w, vrfWrData=memRdata, w increments. After the read for i=VLEN-1 is accepted -> DRAIN.
- DRAIN: performs the final VRF write; no DRAM strobe; -> DONE.
- STORE: memWr=1, memAddr=element address of i, vrfIdx=i, memWdata=vrfRdData. memReady=1 increments i; after i=VLEN-1 accepted -> DONE.
- memReady=0: strobe, address and data held unchanged; i does not advance.
- DONE: done=1 for one cycle, busy=0, -> IDLE. A start in DONE is ignored.
- Reset values: state IDLE; busy, done, memRd, memWr, vrfWrEn = 0; memAddr, memWdata, vrfIdx, vrfWrData, vrfSel = 0.
- Rst mid-access: next cycle all strobes 0, state IDLE; a pending load writeback is discarded.

## Timing
- start at cycle t -> first strobe at t+1, busy high from t+1.
- Load, memReady always 1: reads t+1..t+VLEN, VRF writes t+2..t+VLEN+1, done at t+VLEN+2.
- Store, memReady always 1: writes t+1..t+VLEN, done at t+VLEN+1.
- Each memReady=0 cycle adds one cycle of latency.
- Outputs are registered except memWdata and vrfIdx during STORE, which follow the registered index combinationally.

## Configuration
- VMEM_STRIDE_EN defined: adds input stride (6-bit signed, latched with start, sign-extended to ADDR_W); element address = baseAddr + i*stride, wrap modulo 2^16; stride 0 repeatedly accesses baseAddr.
- Undefined: no stride port; stride fixed at +1.

## Structure
- Package vmem_pkg: state enum, VLEN/DATA_W/ADDR_W defaults, index width constant.
- One sub-module, vmem_idx_gen: issue-index counter plus element-address adder (stride-aware), with load/advance enables and last-element flag.

## Test plan
- Load, baseAddr=0x0100, memReady=1, DRAM[0x0100+k]=0xA000+k -> VRF element k = 0xA000+k, done at t+18, busy t+1..t+17.
- Store, baseAddr=0xFFFE, VRF[k]=k -> DRAM writes 0xFFFE, 0xFFFF, 0x0000..0x000D with data 0..15 (wrap check).
- Load with memReady low on cycles 3 and 7 -> memAddr/memRd held, all 16 elements correct, done delayed by 2 cycles.
- Rst asserted at element 5 of a load -> next cycle memRd=0, vrfWrEn=0, busy=0, no done pulse; following start runs cleanly.
- start asserted while busy and in DONE -> ignored; exactly one done pulse per accepted start.
- With VMEM_STRIDE_EN, stride=-2, baseAddr=0x0010 -> addresses 0x0010, 0x000E, ..., 0xFFF2.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared constants and FSM state encoding for the vector memory sequencer.
package vmem_pkg;

  localparam int unsigned VLEN_DEF   = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned IDX_W_DEF  = $clog2(VLEN_DEF);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STORE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/vmem_idx_gen.sv
// Issue-index counter with a running element address (base + i*stride, wrapping).
module vmem_idx_gen #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  output logic [IDX_W-1:0]  o_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_stride;

  // Address is accumulated rather than multiplied; modulo wrap comes for free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_idx    <= '0;
      r_addr   <= i_base;
      r_stride <= i_stride;
    end else if (i_adv) begin
      r_idx    <= r_idx + IDX_W'(1);
      r_addr   <= r_addr + r_stride;
    end
  end

  assign o_idx  = r_idx;
  assign o_addr = r_addr;
  assign o_last = &r_idx;

endmodule

// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: walks VLEN DRAM words into or out of one vector register.
// Optional VMEM_STRIDE_EN adds a signed 6-bit element stride port.
module vec_mem_seq
  import vmem_pkg::*;
#(
  parameter int unsigned VLEN   = VLEN_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     Clk1,
  input  logic                     Rst,
  input  logic                     start,
  input  logic                     isStore,
  input  logic [ADDR_W-1:0]        baseAddr,
  input  logic [2:0]               vreg,
`ifdef VMEM_STRIDE_EN
  input  logic signed [5:0]        stride,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        memAddr,
  output logic                     memRd,
  output logic                     memWr,
  input  logic                     memReady,
  output logic [DATA_W-1:0]        memWdata,
  input  logic [DATA_W-1:0]        memRdata,
  output logic [2:0]               vrfSel,
  output logic [$clog2(VLEN)-1:0]  vrfIdx,
  output logic                     vrfWrEn,
  output logic [DATA_W-1:0]        vrfWrData,
  input  logic [DATA_W-1:0]        vrfRdData
);

  localparam int unsigned IDX_W = $clog2(VLEN);

  state_e            r_state, w_state_nx;
  logic              r_busy, r_done, r_mem_rd, r_mem_wr, r_vrf_wr_en;
  logic              w_busy_nx, w_done_nx, w_rd_nx, w_wr_nx, w_wr_en_nx;
  logic [2:0]        r_vrf_sel;
  logic [IDX_W-1:0]  r_vrf_idx;
  logic              w_accept, w_adv, w_last;
  logic [IDX_W-1:0]  w_idx;
  logic [ADDR_W-1:0] w_addr, w_stride;

`ifdef VMEM_STRIDE_EN
  assign w_stride = ADDR_W'(stride);
`else
  assign w_stride = ADDR_W'(1);
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_adv    = ((r_state == S_LOAD) || (r_state == S_STORE)) && memReady;

  vmem_idx_gen #(
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) u_idx_gen (
    .i_clk    (Clk1),
    .i_rst    (Rst),
    .i_load   (w_accept),
    .i_adv    (w_adv),
    .i_base   (baseAddr),
    .i_stride (w_stride),
    .o_idx    (w_idx),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  // Next state and next values of the registered strobes.
  always_comb begin
    w_state_nx = r_state;
    w_wr_en_nx = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = isStore ? S_STORE : S_LOAD;
      S_LOAD: begin
        w_wr_en_nx = memReady;
        if (memReady && w_last) w_state_nx = S_DRAIN;
      end
      S_STORE: if (memReady && w_last) w_state_nx = S_DONE;
      S_DRAIN: w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    w_rd_nx   = (w_state_nx == S_LOAD);
    w_wr_nx   = (w_state_nx == S_STORE);
    w_busy_nx = (w_state_nx == S_LOAD) || (w_state_nx == S_STORE) ||
                (w_state_nx == S_DRAIN);
    w_done_nx = (w_state_nx == S_DONE);
  end

  always_ff @(posedge Clk1) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_vrf_wr_en <= 1'b0;
      r_vrf_sel   <= '0;
      r_vrf_idx   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_mem_rd    <= w_rd_nx;
      r_mem_wr    <= w_wr_nx;
      r_vrf_wr_en <= w_wr_en_nx;
      if (w_accept) r_vrf_sel <= vreg;
      // Reads retire in order, so the write index equals the accepted issue index.
      if ((r_state == S_LOAD) && memReady) r_vrf_idx <= w_idx;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign memRd   = r_mem_rd;
  assign memWr   = r_mem_wr;
  assign memAddr = w_addr;
  assign vrfSel  = r_vrf_sel;
  assign vrfWrEn = r_vrf_wr_en;

  // DRAM read data arrives in the write cycle itself, so it is forwarded, gated by the strobe.
  assign vrfWrData = r_vrf_wr_en ? memRdata : '0;
  assign memWdata  = (r_state == S_STORE) ? vrfRdData : '0;
  assign vrfIdx    = (r_state == S_STORE) ? w_idx : r_vrf_idx;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed, table-driven bench for vec_mem_seq with DRAM and VRF behavioural models.
module tb_vec_mem_seq;

  logic        Clk1 = 1'b0;
  logic        Rst, start, isStore, memReady;
  logic [15:0] baseAddr;
  logic [2:0]  vreg;
  logic        busy, done, memRd, memWr, vrfWrEn;
  logic [15:0] memAddr, memWdata, memRdata, vrfWrData, vrfRdData;
  logic [2:0]  vrfSel;
  logic [3:0]  vrfIdx;
`ifdef VMEM_STRIDE_EN
  logic signed [5:0] stride;
`endif

  int errors = 0;
  int checks = 0;
  int tb_stride = 1;

  vec_mem_seq dut (
    .Clk1(Clk1), .Rst(Rst), .start(start), .isStore(isStore),
    .baseAddr(baseAddr), .vreg(vreg),
`ifdef VMEM_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .memAddr(memAddr), .memRd(memRd), .memWr(memWr),
    .memReady(memReady), .memWdata(memWdata), .memRdata(memRdata),
    .vrfSel(vrfSel), .vrfIdx(vrfIdx), .vrfWrEn(vrfWrEn),
    .vrfWrData(vrfWrData), .vrfRdData(vrfRdData)
  );

  always #5 Clk1 = ~Clk1;

  function automatic logic [15:0] dram_val(input logic [15:0] a);
    if (a >= 16'h0100 && a < 16'h0110) return 16'hA000 + (a - 16'h0100);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] vrf_val(input logic [2:0] v, input int k);
    return (16'(v) << 8) | 16'(k);
  endfunction

  function automatic logic [15:0] exp_addr(input logic [15:0] base, input int k);
    return 16'(int'(base) + k * tb_stride);
  endfunction

  // DRAM returns read data the cycle after an accepted read; VRF read is combinational.
  initial memRdata = 16'h0;
  always @(posedge Clk1) memRdata <= (memRd && memReady) ? dram_val(memAddr) : 16'h0;
  assign vrfRdData = vrf_val(vrfSel, int'(vrfIdx));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          st;
    logic [15:0] base;
    logic [2:0]  vreg;
    int          sa, sb;     // memReady low on these cycles (0 = none)
    int          xa, xb;     // spurious start pulses on these cycles (0 = none)
    int          e_done;
    int          e_blast;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int busy_first = -1, busy_last = -1, done_cyc = -1, ndone = 0;
    int nacc = 0, nwr = 0, addrbad = 0, databad = 0, conflict = 0, holdbad = 0, selbad = 0;
    bit prev_stall = 0;
    logic [15:0] p_addr = '0, p_wdata = '0;
    logic p_rd = 0, p_wr = 0;
    @(negedge Clk1);
    start = 1; isStore = v.st; baseAddr = v.base; vreg = v.vreg; memReady = 1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge Clk1);
      start    = (c == v.xa) || (c == v.xb);
      isStore  = start ? ~v.st : v.st;
      baseAddr = start ? 16'h7777 : v.base;
      memReady = !((c == v.sa) || (c == v.sb));
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        if (vrfSel != v.vreg) selbad++;
      end
      if (done) begin ndone++; done_cyc = c; end
      if (memRd && memWr) conflict++;
      if (prev_stall && (memAddr != p_addr || memRd != p_rd || memWr != p_wr ||
                         memWdata != p_wdata)) holdbad++;
      prev_stall = (memRd || memWr) && !memReady;
      p_addr = memAddr; p_rd = memRd; p_wr = memWr; p_wdata = memWdata;
      if ((memRd || memWr) && memReady) begin
        if (memAddr != exp_addr(v.base, nacc)) begin
          if (addrbad == 0)
            $display("  %s access %0d at 0x%0h, want 0x%0h", tag, nacc, memAddr, exp_addr(v.base, nacc));
          addrbad++;
        end
        if (memWr && memWdata != vrf_val(v.vreg, nacc)) databad++;
        nacc++;
      end
      if (vrfWrEn) begin
        if (int'(vrfIdx) != nwr || vrfWrData != dram_val(exp_addr(v.base, nwr))) databad++;
        nwr++;
      end
    end
    start = 0; isStore = 0; memReady = 1;
    chk({tag, " busy_first"}, busy_first, 1);
    chk({tag, " busy_last"}, busy_last, v.e_blast);
    chk({tag, " done_cycle"}, done_cyc, v.e_done);
    chk({tag, " done_pulses"}, ndone, 1);
    chk({tag, " accesses"}, nacc, 16);
    chk({tag, " vrf_writes"}, nwr, v.st ? 0 : 16);
    chk({tag, " addr_errs"}, addrbad, 0);
    chk({tag, " data_errs"}, databad, 0);
    chk({tag, " rd_wr_both"}, conflict, 0);
    chk({tag, " stall_hold"}, holdbad, 0);
    chk({tag, " vrf_sel"}, selbad, 0);
  endtask

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int nd, ns;
    tbl[0] = '{st:0, base:16'h0100, vreg:3'd2, sa:0, sb:0,  xa:0, xb:0,  e_done:18, e_blast:17};
    tbl[1] = '{st:1, base:16'hFFFE, vreg:3'd0, sa:0, sb:0,  xa:0, xb:0,  e_done:17, e_blast:16};
    tbl[2] = '{st:0, base:16'h0100, vreg:3'd3, sa:3, sb:7,  xa:0, xb:0,  e_done:20, e_blast:19};
    tbl[3] = '{st:1, base:16'h1234, vreg:3'd1, sa:1, sb:16, xa:0, xb:0,  e_done:19, e_blast:18};
    tbl[4] = '{st:0, base:16'hFFF8, vreg:3'd7, sa:16, sb:0, xa:0, xb:0,  e_done:19, e_blast:18};
    tbl[5] = '{st:0, base:16'h0100, vreg:3'd4, sa:0, sb:0,  xa:5, xb:18, e_done:18, e_blast:17};

    Rst = 1; start = 0; isStore = 0; memReady = 1; baseAddr = '0; vreg = '0;
`ifdef VMEM_STRIDE_EN
    stride = 6'sd1;
`endif
    repeat (3) @(posedge Clk1);
    @(negedge Clk1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst strobes", {memRd, memWr, vrfWrEn}, 0);
    chk("rst memAddr", memAddr, 0);
    chk("rst memWdata", memWdata, 0);
    chk("rst vrf_out", {vrfSel, vrfIdx, vrfWrData}, 0);
    Rst = 0;

    // Reset in the middle of a load, while element 5 is being read.
    @(negedge Clk1);
    start = 1; isStore = 0; baseAddr = 16'h0100; vreg = 3'd6;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk1);
      start = 0;
    end
    chk("midrst pre memRd", memRd, 1);
    chk("midrst pre addr", memAddr, 16'h0105);
    Rst = 1;
    @(negedge Clk1);
    chk("midrst memRd", memRd, 0);
    chk("midrst vrfWrEn", vrfWrEn, 0);
    chk("midrst busy", busy, 0);
    chk("midrst vrfWrData", vrfWrData, 0);
    Rst = 0;
    nd = 0; ns = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk1);
      if (done) nd++;
      if (memRd || memWr || vrfWrEn || busy) ns++;
    end
    chk("midrst done_pulses", nd, 0);
    chk("midrst activity", ns, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

`ifdef VMEM_STRIDE_EN
    tb_stride = -2;
    stride = -6'sd2;
    run_vec("stride_neg2", '{st:0, base:16'h0010, vreg:3'd1, sa:0, sb:0, xa:0, xb:0,
                             e_done:18, e_blast:17});
    chk("stride last addr", exp_addr(16'h0010, 15), 16'hFFF2);
    tb_stride = 1;
    stride = 6'sd1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
